// File: rtl/seq_divider.sv
// Iterative restoring shift-subtract divider resolving one quotient bit per clock.
// Define DIVIDER_SIGNED_EN to build a two's-complement signed divider; default is unsigned.
module seq_divider #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_a1,
    input  logic [WIDTH-1:0] i_b1,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_y,
    output logic [WIDTH-1:0] o_z,
    output logic             o_dz
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]       r_state;
    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_dzPend;

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH+1:0] w_trial;
    logic             w_trialNeg;
    logic [WIDTH-1:0] w_absA;
    logic [WIDTH-1:0] w_absB;

`ifdef DIVIDER_SIGNED_EN
    logic r_negQuo;
    logic r_negRem;

    assign w_absA = i_a1[WIDTH-1] ? -i_a1 : i_a1;
    assign w_absB = i_b1[WIDTH-1] ? -i_b1 : i_b1;
`else
    assign w_absA = i_a1;
    assign w_absB = i_b1;
`endif

    // Extra top bit keeps the borrow of the trial subtraction visible as a sign.
    assign w_shift    = {r_rem, r_quo[WIDTH-1]};
    assign w_trial    = w_shift - {2'b00, r_div};
    assign w_trialNeg = w_trial[WIDTH+1];

    assign o_busy = (r_state == S_RUN) || (r_state == S_FIX);
    assign o_done = (r_state == S_DONE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_count  <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
            r_dzPend <= 1'b0;
            o_y      <= '0;
            o_z      <= '0;
            o_dz     <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
            r_negQuo <= 1'b0;
            r_negRem <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_count <= '0;
                        // A zero divisor skips RUN and reports the raw dividend as remainder.
                        if (i_b1 == '0) begin
                            r_dzPend <= 1'b1;
                            r_rem    <= {1'b0, i_a1};
                            r_state  <= S_FIX;
                        end else begin
                            r_dzPend <= 1'b0;
                            r_rem    <= '0;
                            r_quo    <= w_absA;
                            r_div    <= w_absB;
                            r_state  <= S_RUN;
                        end
`ifdef DIVIDER_SIGNED_EN
                        r_negQuo <= i_a1[WIDTH-1] ^ i_b1[WIDTH-1];
                        r_negRem <= i_a1[WIDTH-1];
`endif
                    end
                end
                S_RUN: begin
                    r_quo   <= {r_quo[WIDTH-2:0], ~w_trialNeg};
                    r_rem   <= w_trialNeg ? w_shift[WIDTH:0] : w_trial[WIDTH:0];
                    r_count <= r_count + 1'b1;
                    if (r_count == CW'(WIDTH - 1)) begin
                        r_state <= S_FIX;
                    end
                end
                S_FIX: begin
                    if (r_dzPend) begin
                        o_y  <= '1;
                        o_z  <= r_rem[WIDTH-1:0];
                        o_dz <= 1'b1;
                    end else begin
`ifdef DIVIDER_SIGNED_EN
                        o_y  <= r_negQuo ? -r_quo : r_quo;
                        o_z  <= r_negRem ? -r_rem[WIDTH-1:0] : r_rem[WIDTH-1:0];
`else
                        o_y  <= r_quo;
                        o_z  <= r_rem[WIDTH-1:0];
`endif
                        o_dz <= 1'b0;
                    end
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake scenarios plus randomized operands
// compared against an arithmetic reference model (honours DIVIDER_SIGNED_EN).
module tb_seq_divider;

    logic        clk;
    logic        i_rst;
    logic        i_start;
    logic [31:0] i_a1;
    logic [31:0] i_b1;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_y;
    logic [31:0] o_z;
    logic        o_dz;

    int nTests = 0;
    int nFail  = 0;

    seq_divider #(.WIDTH(32)) dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_a1   (i_a1),
        .i_b1   (i_b1),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_y    (o_y),
        .o_z    (o_z),
        .o_dz   (o_dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain arithmetic on the operands, not a bit-serial model.
    function automatic void refDivide(input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] y, output logic [31:0] z,
                                      output logic dz);
        if (b == 32'd0) begin
            y  = 32'hFFFFFFFF;
            z  = a;
            dz = 1'b1;
        end else begin
`ifdef DIVIDER_SIGNED_EN
            if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
                y = 32'h80000000;
                z = 32'd0;
            end else begin
                y = $signed(a) / $signed(b);
                z = $signed(a) % $signed(b);
            end
`else
            y = a / b;
            z = a % b;
`endif
            dz = 1'b0;
        end
    endfunction

    // Issues one start pulse and waits (bounded) for done; operands are scrambled after accept.
    task automatic runOp(input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busyCnt);
        i_a1    = a;
        i_b1    = b;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        i_a1    = $urandom;
        i_b1    = $urandom;
        lat     = 1;
        busyCnt = 0;
        while (o_done !== 1'b1 && lat < 100) begin
            if (o_busy === 1'b1) busyCnt++;
            tick();
            lat++;
        end
    endtask

    task automatic checkResult(input string name, input logic [31:0] a, input logic [31:0] b,
                               input int lat);
        logic [31:0] ey, ez;
        logic        edz;
        int          elat;
        refDivide(a, b, ey, ez, edz);
        elat = edz ? 2 : 34;
        nTests += 4;
        if (lat !== elat) begin
            nFail++;
            $display("[TB] FAIL %s latency: got %0d expected %0d", name, lat, elat);
        end
        if (o_y !== ey) begin
            nFail++;
            $display("[TB] FAIL %s y (a=%h b=%h): got %h expected %h", name, a, b, o_y, ey);
        end
        if (o_z !== ez) begin
            nFail++;
            $display("[TB] FAIL %s z (a=%h b=%h): got %h expected %h", name, a, b, o_z, ez);
        end
        if (o_dz !== edz) begin
            nFail++;
            $display("[TB] FAIL %s dz: got %b expected %b", name, o_dz, edz);
        end
    endtask

    task automatic test_reset();
        i_rst   = 1'b1;
        i_start = 1'b1;
        i_a1    = 32'd5;
        i_b1    = 32'd1;
        tick();
        tick();
        i_rst   = 1'b0;
        i_start = 1'b0;
        nTests++;
        if ({o_busy, o_done, o_dz} !== 3'b000 || o_y !== 32'd0 || o_z !== 32'd0) begin
            nFail++;
            $display("[TB] FAIL reset state: busy=%b done=%b dz=%b y=%h z=%h expected all zero",
                     o_busy, o_done, o_dz, o_y, o_z);
        end
        tick();
        nTests++;
        if (o_busy !== 1'b0) begin
            nFail++;
            $display("[TB] FAIL start_with_reset: busy=%b expected 0", o_busy);
        end
    endtask

    task automatic test_basic();
        int lat, busyCnt;
        runOp(32'd100, 32'd7, lat, busyCnt);
        nTests += 6;
        if (lat !== 34) begin nFail++; $display("[TB] FAIL basic latency: got %0d expected 34", lat); end
        if (busyCnt !== 33) begin nFail++; $display("[TB] FAIL basic busy cycles: got %0d expected 33", busyCnt); end
        if (o_busy !== 1'b0) begin nFail++; $display("[TB] FAIL basic busy at done: got %b expected 0", o_busy); end
        if (o_y !== 32'd14) begin nFail++; $display("[TB] FAIL basic y: got %0d expected 14", o_y); end
        if (o_z !== 32'd2) begin nFail++; $display("[TB] FAIL basic z: got %0d expected 2", o_z); end
        if (o_dz !== 1'b0) begin nFail++; $display("[TB] FAIL basic dz: got %b expected 0", o_dz); end
        tick();
        nTests++;
        if (o_done !== 1'b0) begin nFail++; $display("[TB] FAIL done pulse width: done=%b expected 0", o_done); end
`ifdef DIVIDER_SIGNED_EN
        runOp(32'hFFFFFFF9, 32'd2, lat, busyCnt);
        checkResult("signed_neg7_by_2", 32'hFFFFFFF9, 32'd2, lat);
`else
        runOp(32'hFFFFFFFF, 32'd1, lat, busyCnt);
        checkResult("max_by_1", 32'hFFFFFFFF, 32'd1, lat);
`endif
        tick();
    endtask

    task automatic test_div_zero();
        int lat, busyCnt;
        runOp(32'd1234, 32'd0, lat, busyCnt);
        checkResult("div_zero", 32'd1234, 32'd0, lat);
        nTests++;
        if (busyCnt !== 1) begin nFail++; $display("[TB] FAIL div_zero busy cycles: got %0d expected 1", busyCnt); end
        repeat (3) tick();
        nTests++;
        if (o_y !== 32'hFFFFFFFF || o_z !== 32'd1234 || o_dz !== 1'b1) begin
            nFail++;
            $display("[TB] FAIL div_zero hold: y=%h z=%h dz=%b expected ffffffff/000004d2/1", o_y, o_z, o_dz);
        end
        runOp(32'd9, 32'd3, lat, busyCnt);
        checkResult("after_div_zero", 32'd9, 32'd3, lat);
        tick();
    endtask

    task automatic test_ignore_start();
        int lat, extra;
        i_a1    = 32'd20;
        i_b1    = 32'd5;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        lat     = 1;
        while (o_done !== 1'b1 && lat < 100) begin
            i_start = (lat == 10);
            if (lat == 10) begin
                i_a1 = 32'd99;
                i_b1 = 32'd9;
            end
            tick();
            lat++;
        end
        i_start = 1'b0;
        checkResult("ignore_busy_start", 32'd20, 32'd5, lat);
        extra = 0;
        repeat (45) begin
            tick();
            if (o_done === 1'b1 || o_busy === 1'b1) extra++;
        end
        nTests++;
        if (extra !== 0) begin nFail++; $display("[TB] FAIL ignored start activity: got %0d cycles expected 0", extra); end
    endtask

    task automatic test_reset_abort();
        int lat, busyCnt, extra;
        i_a1    = 32'd1000;
        i_b1    = 32'd3;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (14) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        nTests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_y !== 32'd0 || o_z !== 32'd0) begin
            nFail++;
            $display("[TB] FAIL abort state: busy=%b done=%b y=%h z=%h expected 0/0/0/0", o_busy, o_done, o_y, o_z);
        end
        extra = 0;
        repeat (40) begin
            tick();
            if (o_done === 1'b1) extra++;
        end
        nTests++;
        if (extra !== 0) begin nFail++; $display("[TB] FAIL abort done pulses: got %0d expected 0", extra); end
        runOp(32'd50, 32'd8, lat, busyCnt);
        checkResult("after_abort", 32'd50, 32'd8, lat);
        tick();
    endtask

    task automatic test_signed_overflow();
`ifdef DIVIDER_SIGNED_EN
        int lat, busyCnt;
        runOp(32'h80000000, 32'hFFFFFFFF, lat, busyCnt);
        checkResult("signed_overflow", 32'h80000000, 32'hFFFFFFFF, lat);
        tick();
`endif
    endtask

    task automatic test_back_to_back();
        int lat, busyCnt;
        runOp(32'd9, 32'd3, lat, busyCnt);
        checkResult("b2b_first", 32'd9, 32'd3, lat);
        i_a1    = 32'd77;
        i_b1    = 32'd7;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        nTests++;
        if (o_busy !== 1'b0) begin nFail++; $display("[TB] FAIL start in done: busy=%b expected 0", o_busy); end
        runOp(32'd77, 32'd7, lat, busyCnt);
        checkResult("b2b_second", 32'd77, 32'd7, lat);
        repeat (3) tick();
        nTests++;
        if (o_y !== 32'd11 || o_z !== 32'd0) begin
            nFail++;
            $display("[TB] FAIL result hold: y=%0d z=%0d expected 11/0", o_y, o_z);
        end
    endtask

    task automatic test_random();
        int lat, busyCnt;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = $urandom_range(1, 15);
                2:       b = 32'hFFFFFFFF - $urandom_range(0, 3);
                default: b = $urandom >> $urandom_range(0, 28);
            endcase
            runOp(a, b, lat, busyCnt);
            checkResult("random", a, b, lat);
            tick();
        end
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_a1    = 32'd0;
        i_b1    = 32'd0;
        test_reset();
        test_basic();
        test_div_zero();
        test_ignore_start();
        test_reset_abort();
        test_signed_overflow();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
